// File: rtl/subn_arbiter_pkg.sv
// Shared definitions for the subn_arbiter slice: FSM encoding and datapath sizing.
package subn_arbiter_pkg;

    localparam int SUBN_W    = 16;
    localparam int N_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted valid scanning ptr, ptr+1, ... with wrap.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && valid[IW'(j)]) begin
                any             = 1'b1;
                grant[IW'(j)]   = 1'b1;
                idx             = IW'(j);
            end
        end
    end

endmodule

// File: rtl/subn.sv
// Shared subtractor datapath: d = a - b, c is the borrow out (a < b unsigned).
module subn #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         c
);

    assign {c, d} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/subn_arbiter.sv
// Round-robin arbiter sharing one subn subtractor between N_REQ requesters.
// Define SUBN_ARB_SAT_EN to clamp the difference to 0 whenever a borrow occurs.
module subn_arbiter
    import subn_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [SUBN_W*N_REQ-1:0] req_a,
    input  logic [SUBN_W*N_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SUBN_W-1:0]       rsp_d,
    output logic                    rsp_borrow,
    output state_t                  dbg_state
);

    // Handshake: a request i transfers on a cycle with req_valid[i] & req_ready[i];
    // a response transfers on a cycle with rsp_valid & rsp_ready. Neither ready
    // depends on the same channel's valid except through the one-hot grant.

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id_q;
    logic [SUBN_W-1:0]   op_a, op_b;
    logic [SUBN_W-1:0]   sel_a, sel_b;
    logic [SUBN_W-1:0]   sub_d, d_res;
    logic                sub_c;
    logic [N_REQ-1:0]    pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic                accept_win;
    logic                accept;

    rr_pick #(.N(N_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    subn #(.W(SUBN_W)) u_subn (
        .a (op_a),
        .b (op_b),
        .d (sub_d),
        .c (sub_c)
    );

`ifdef SUBN_ARB_SAT_EN
    assign d_res = sub_c ? '0 : sub_d;
`else
    assign d_res = sub_d;
`endif

    // Retiring a response and accepting the next request share the same cycle.
    assign accept_win = !rst && ((state == IDLE) || (state == RESP && rsp_ready));
    assign accept     = accept_win && pick_any;
    assign req_ready  = accept_win ? pick_grant : '0;
    assign rsp_valid  = (state == RESP);
    assign dbg_state  = state;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                sel_a = req_a[SUBN_W*i +: SUBN_W];
                sel_b = req_b[SUBN_W*i +: SUBN_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = pick_any ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            id_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_d      <= '0;
            rsp_borrow <= 1'b0;
            rsp_id     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a <= sel_a;
                op_b <= sel_b;
                id_q <= pick_idx;
                ptr  <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (state == CALC) begin
                rsp_d      <= d_res;
                rsp_borrow <= sub_c;
                rsp_id     <= id_q;
            end
        end
    end

endmodule
